system_memory_v5: RTL and testbench

//  Grid state memory for the Conway engine, successor to the v4 single-shift-register memory.

---
 rtl/conway_mem_pkg.sv | 20 ++
 rtl/frame_beat_counter.sv | 53 +++++
 rtl/system_memory_v5.sv | 139 +++++++++++++
 tb/tb_system_memory_v5.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conway_mem_pkg.sv
// Shared types and sizing helpers for the Conway grid state memory.
package conway_mem_pkg;

   typedef enum logic [1:0] {
      MEM_IDLE = 2'd0,
      MEM_LOAD = 2'd1,
      MEM_DUMP = 2'd2
   } mem_state_t;

   // Number of serial beats that move one full frame.
   function automatic int unsigned beats(input int unsigned n, input int unsigned lanes);
      return n / lanes;
   endfunction

   // Beat counter width; a single-beat frame still needs one bit.
   function automatic int unsigned cnt_w(input int unsigned b);
      return (b > 1) ? $clog2(b) : 1;
   endfunction

endpackage

// File: rtl/frame_beat_counter.sv
// Counts beats within one frame and flags the final beat; shared by load and dump.
module frame_beat_counter
   import conway_mem_pkg::*;
#(
   parameter  int unsigned BEATS = 16,
   localparam int unsigned CW    = cnt_w(BEATS)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          clr_i,
   input  logic          inc_i,
   output logic          last_o,
   output logic [CW-1:0] count_o
);

   localparam logic [CW-1:0] LAST_IDX      = CW'(BEATS - 1);
   localparam logic          LAST_ON_ENTRY = (BEATS == 1);

   logic [CW-1:0] count_q, count_d;
   logic          last_q, last_d;

   // last is precomputed so the final beat is known without a compare in the frame path
   always_comb begin
      count_d = count_q;
      last_d  = last_q;
      if (clr_i) begin
         count_d = '0;
         last_d  = LAST_ON_ENTRY;
      end else if (inc_i) begin
         if (count_q == LAST_IDX) begin
            count_d = '0;
            last_d  = LAST_ON_ENTRY;
         end else begin
            count_d = count_q + CW'(1);
            last_d  = ((count_q + CW'(1)) == LAST_IDX);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
         last_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         last_q  <= last_d;
      end
   end

   assign last_o  = last_q;
   assign count_o = count_q;

endmodule

// File: rtl/system_memory_v5.sv
// Conway grid state memory: captures generations, loads and dumps frames over a serial bus,
// and counts captured generations.
module system_memory_v5
   import conway_mem_pkg::*;
#(
   parameter  int unsigned ROWS  = 8,
   parameter  int unsigned COLS  = 8,
   parameter  int unsigned LANES = 1,
   parameter  int unsigned GEN_W = 16,
   localparam int unsigned N     = ROWS * COLS
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [N-1:0]     GRID_IN,
   input  logic             GRID_VALID,
   input  logic             LOAD_REQ,
   input  logic             DUMP_REQ,
   input  logic [LANES-1:0] SERIAL_IN,
   input  logic             SERIAL_IN_VALID,
   output logic [N-1:0]     SYSTEM_MEM_OUT,
   output logic [LANES-1:0] SERIAL_OUT,
   output logic             SERIAL_OUT_VALID,
   output logic             BUSY,
   output logic             FRAME_DONE,
   output logic [GEN_W-1:0] GENERATION
);

   localparam int unsigned BEATS = beats(N, LANES);
   localparam int unsigned CW    = cnt_w(BEATS);

   if ((N % LANES) != 0) begin : g_lane_check
      $error("system_memory_v5: grid size must be a multiple of LANES");
   end

   mem_state_t       state_q, state_d;
   logic [N-1:0]     mem_q, mem_d;
   logic [GEN_W-1:0] gen_q, gen_d;
   logic [LANES-1:0] sout_q, sout_d;
   logic             sout_valid_q, sout_valid_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;

   logic             beat_clr;
   logic             beat_inc;
   logic             beat_last;
   logic [CW-1:0]    beat_cnt;

   frame_beat_counter #(.BEATS(BEATS)) u_beat_cnt (
      .clk_i   (CLK),
      .rst_i   (RESET),
      .clr_i   (beat_clr),
      .inc_i   (beat_inc),
      .last_o  (beat_last),
      .count_o (beat_cnt)
   );

   // Next-state and output decode; shifts use truncating casts so LANES == N needs no special case
   always_comb begin
      state_d      = state_q;
      mem_d        = mem_q;
      gen_d        = gen_q;
      sout_d       = '0;
      sout_valid_d = 1'b0;
      done_d       = 1'b0;
      beat_clr     = 1'b0;
      beat_inc     = 1'b0;

      unique case (state_q)
         MEM_IDLE: begin
            if (GRID_VALID) begin
               mem_d = GRID_IN;
               gen_d = gen_q + GEN_W'(1);
            end else if (LOAD_REQ) begin
               state_d  = MEM_LOAD;
               beat_clr = 1'b1;
            end else if (DUMP_REQ) begin
               state_d  = MEM_DUMP;
               beat_clr = 1'b1;
            end
         end
         MEM_LOAD: begin
            if (SERIAL_IN_VALID) begin
               mem_d    = N'({mem_q, SERIAL_IN});
               beat_inc = 1'b1;
               if (beat_last) begin
                  done_d  = 1'b1;
                  gen_d   = '0;
                  state_d = MEM_IDLE;
               end
            end
         end
         MEM_DUMP: begin
            sout_d       = mem_q[N-1 -: LANES];
            sout_valid_d = 1'b1;
            mem_d        = N'({mem_q, mem_q[N-1 -: LANES]});
            beat_inc     = 1'b1;
            if (beat_last) begin
               done_d  = 1'b1;
               state_d = MEM_IDLE;
            end
         end
         default: state_d = MEM_IDLE;
      endcase

      busy_d = (state_d != MEM_IDLE);
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q      <= MEM_IDLE;
         mem_q        <= '0;
         gen_q        <= '0;
         sout_q       <= '0;
         sout_valid_q <= 1'b0;
         done_q       <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         mem_q        <= mem_d;
         gen_q        <= gen_d;
         sout_q       <= sout_d;
         sout_valid_q <= sout_valid_d;
         done_q       <= done_d;
         busy_q       <= busy_d;
      end
   end

   // Precomputed last flag must agree with the beat index throughout a frame
   a_last_consistent: assert property (@(posedge CLK) disable iff (RESET)
      (state_q != MEM_IDLE) |-> (beat_last == (beat_cnt == CW'(BEATS - 1))));

   assign SYSTEM_MEM_OUT   = mem_q;
   assign SERIAL_OUT       = sout_q;
   assign SERIAL_OUT_VALID = sout_valid_q;
   assign BUSY             = busy_q;
   assign FRAME_DONE       = done_q;
   assign GENERATION       = gen_q;

endmodule

// File: tb/tb_system_memory_v5.sv
// Scoreboard bench for system_memory_v5: LANES=4 main instance plus GEN_W=2, LANES=64 and LANES=1 variants.
module tb_system_memory_v5;

   logic CLK;
   logic RESET;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // ---------------- instance a: LANES=4, GEN_W=16 ----------------
   logic [63:0] a_grid_in, a_mem;
   logic        a_gv, a_lr, a_dr, a_siv, a_sov, a_busy, a_done;
   logic [3:0]  a_si, a_so;
   logic [15:0] a_gen;

   system_memory_v5 #(.ROWS(8), .COLS(8), .LANES(4), .GEN_W(16)) u_a (
      .CLK(CLK), .RESET(RESET), .GRID_IN(a_grid_in), .GRID_VALID(a_gv),
      .LOAD_REQ(a_lr), .DUMP_REQ(a_dr), .SERIAL_IN(a_si), .SERIAL_IN_VALID(a_siv),
      .SYSTEM_MEM_OUT(a_mem), .SERIAL_OUT(a_so), .SERIAL_OUT_VALID(a_sov),
      .BUSY(a_busy), .FRAME_DONE(a_done), .GENERATION(a_gen)
   );

   // ---------------- instance g: LANES=4, GEN_W=2 ----------------
   logic [63:0] g_grid_in, g_mem;
   logic        g_gv, g_lr, g_dr, g_siv, g_sov, g_busy, g_done;
   logic [3:0]  g_si, g_so;
   logic [1:0]  g_gen;

   system_memory_v5 #(.ROWS(8), .COLS(8), .LANES(4), .GEN_W(2)) u_g (
      .CLK(CLK), .RESET(RESET), .GRID_IN(g_grid_in), .GRID_VALID(g_gv),
      .LOAD_REQ(g_lr), .DUMP_REQ(g_dr), .SERIAL_IN(g_si), .SERIAL_IN_VALID(g_siv),
      .SYSTEM_MEM_OUT(g_mem), .SERIAL_OUT(g_so), .SERIAL_OUT_VALID(g_sov),
      .BUSY(g_busy), .FRAME_DONE(g_done), .GENERATION(g_gen)
   );

   // ---------------- instance w: LANES=64 ----------------
   logic [63:0] w_grid_in, w_mem, w_si, w_so;
   logic        w_gv, w_lr, w_dr, w_siv, w_sov, w_busy, w_done;
   logic [15:0] w_gen;

   system_memory_v5 #(.ROWS(8), .COLS(8), .LANES(64), .GEN_W(16)) u_w (
      .CLK(CLK), .RESET(RESET), .GRID_IN(w_grid_in), .GRID_VALID(w_gv),
      .LOAD_REQ(w_lr), .DUMP_REQ(w_dr), .SERIAL_IN(w_si), .SERIAL_IN_VALID(w_siv),
      .SYSTEM_MEM_OUT(w_mem), .SERIAL_OUT(w_so), .SERIAL_OUT_VALID(w_sov),
      .BUSY(w_busy), .FRAME_DONE(w_done), .GENERATION(w_gen)
   );

   // ---------------- instance s: LANES=1 ----------------
   logic [63:0] s_grid_in, s_mem;
   logic        s_gv, s_lr, s_dr, s_siv, s_sov, s_busy, s_done;
   logic [0:0]  s_si, s_so;
   logic [15:0] s_gen;

   system_memory_v5 #(.ROWS(8), .COLS(8), .LANES(1), .GEN_W(16)) u_s (
      .CLK(CLK), .RESET(RESET), .GRID_IN(s_grid_in), .GRID_VALID(s_gv),
      .LOAD_REQ(s_lr), .DUMP_REQ(s_dr), .SERIAL_IN(s_si), .SERIAL_IN_VALID(s_siv),
      .SYSTEM_MEM_OUT(s_mem), .SERIAL_OUT(s_so), .SERIAL_OUT_VALID(s_sov),
      .BUSY(s_busy), .FRAME_DONE(s_done), .GENERATION(s_gen)
   );

   // ---------------- scoreboards ----------------
   logic [3:0]  q4[$];
   logic [63:0] q64[$];
   logic [0:0]  q1[$];

   always @(posedge CLK) begin
      #1;
      if (a_sov) begin
         if (q4.size() == 0) check("a_beat_unexpected", 64'(q4.size()), 64'd1);
         else                check("a_beat", 64'(a_so), 64'(q4.pop_front()));
      end else begin
         check("a_idle_out", 64'(a_so), 64'd0);
      end
   end

   always @(posedge CLK) begin
      #1;
      if (w_sov) begin
         if (q64.size() == 0) check("w_beat_unexpected", 64'(q64.size()), 64'd1);
         else                 check("w_beat", w_so, q64.pop_front());
      end
   end

   always @(posedge CLK) begin
      #1;
      if (s_sov) begin
         if (q1.size() == 0) check("s_beat_unexpected", 64'(q1.size()), 64'd1);
         else                check("s_beat", 64'(s_so), 64'(q1.pop_front()));
      end
   end

   function automatic void push4(input logic [63:0] m, input int n);
      for (int i = 0; i < n; i++) q4.push_back(m[63-4*i -: 4]);
   endfunction

   // Dump on instance a; optionally poke requests on the first busy cycle (they must be ignored)
   task automatic dump_a(input logic [63:0] m, input bit poke);
      int n;
      push4(m, 16);
      a_dr = 1'b1;
      tick();
      a_dr = 1'b0;
      check("dump_busy", 64'(a_busy), 64'd1);
      n = 0;
      while (!a_done && n < 40) begin
         if (poke && n == 0) begin
            a_gv = 1'b1; a_grid_in = '1; a_lr = 1'b1;
         end
         tick();
         a_gv = 1'b0; a_lr = 1'b0;
         n++;
      end
      check("dump_len", 64'(n), 64'd16);
      check("dump_idle_after", 64'(a_busy), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      int n;
      logic [63:0] pat;

      RESET = 1'b1;
      a_grid_in = '0; a_gv = 0; a_lr = 0; a_dr = 0; a_si = '0; a_siv = 0;
      g_grid_in = '0; g_gv = 0; g_lr = 0; g_dr = 0; g_si = '0; g_siv = 0;
      w_grid_in = '0; w_gv = 0; w_lr = 0; w_dr = 0; w_si = '0; w_siv = 0;
      s_grid_in = '0; s_gv = 0; s_lr = 0; s_dr = 0; s_si = '0; s_siv = 0;
      tick(); tick();
      check("rst_mem", a_mem, 64'd0);
      check("rst_busy", 64'(a_busy), 64'd0);
      check("rst_gen", 64'(a_gen), 64'd0);
      check("rst_done", 64'(a_done), 64'd0);
      check("rst_sov", 64'(a_sov), 64'd0);
      RESET = 1'b0;
      tick();

      // 1: reset mid-dump
      a_grid_in = 64'hA5C3_0F96_1234_5678; a_gv = 1'b1;
      tick();
      a_gv = 1'b0;
      check("t1_capture", a_mem, 64'hA5C3_0F96_1234_5678);
      check("t1_gen", 64'(a_gen), 64'd1);
      push4(64'hA5C3_0F96_1234_5678, 4);
      a_dr = 1'b1;
      tick();
      a_dr = 1'b0;
      check("t1_busy", 64'(a_busy), 64'd1);
      repeat (4) tick();
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
      check("t1_rst_mem", a_mem, 64'd0);
      check("t1_rst_busy", 64'(a_busy), 64'd0);
      check("t1_rst_gen", 64'(a_gen), 64'd0);
      check("t1_rst_sov", 64'(a_sov), 64'd0);
      check("t1_rst_so", 64'(a_so), 64'd0);
      check("t1_rst_done", 64'(a_done), 64'd0);
      check("t1_q_drained", 64'(q4.size()), 64'd0);
      dump_a(64'd0, 1'b0);
      check("t1_zero_mem", a_mem, 64'd0);

      // 2: load with gaps clears generation
      a_grid_in = 64'hDEAD_BEEF_0000_0001; a_gv = 1'b1;
      tick();
      a_gv = 1'b0;
      check("t2_gen_pre", 64'(a_gen), 64'd1);
      a_lr = 1'b1;
      tick();
      a_lr = 1'b0;
      check("t2_busy", 64'(a_busy), 64'd1);
      for (int i = 0; i < 16; i++) begin
         if (i == 3 || i == 7 || i == 11) begin
            a_siv = 1'b0; a_si = 4'h5;
            tick();
         end
         a_si = 4'(15 - i); a_siv = 1'b1;
         tick();
         if (i == 14) check("t2_done_early", 64'(a_done), 64'd0);
      end
      a_siv = 1'b0;
      check("t2_mem", a_mem, 64'hFEDC_BA98_7654_3210);
      check("t2_done", 64'(a_done), 64'd1);
      check("t2_gen", 64'(a_gen), 64'd0);
      check("t2_busy_end", 64'(a_busy), 64'd0);
      tick();
      check("t2_done_pulse", 64'(a_done), 64'd0);

      // 3: dump preserves memory; back-to-back dump repeats
      dump_a(64'hFEDC_BA98_7654_3210, 1'b0);
      check("t3_mem1", a_mem, 64'hFEDC_BA98_7654_3210);
      dump_a(64'hFEDC_BA98_7654_3210, 1'b0);
      check("t3_mem2", a_mem, 64'hFEDC_BA98_7654_3210);

      // 4: capture beats a simultaneous load; requests during dump ignored
      tick();
      a_grid_in = 64'h1; a_gv = 1'b1; a_lr = 1'b1;
      tick();
      a_gv = 1'b0; a_lr = 1'b0;
      check("t4_mem", a_mem, 64'h1);
      check("t4_gen", 64'(a_gen), 64'd1);
      check("t4_busy", 64'(a_busy), 64'd0);
      dump_a(64'h1, 1'b1);
      check("t4_mem_after", a_mem, 64'h1);
      check("t4_gen_after", 64'(a_gen), 64'd1);
      tick();
      check("t4_still_idle", 64'(a_busy), 64'd0);

      // 5: narrow generation counter wraps
      for (int i = 0; i < 5; i++) begin
         g_grid_in = 64'(i + 100); g_gv = 1'b1;
         tick();
         g_gv = 1'b0;
         check("t5_gen", 64'(g_gen), 64'((i + 1) % 4));
         check("t5_mem", g_mem, 64'(i + 100));
      end

      // 6a: LANES=64 single-beat load and dump
      w_lr = 1'b1;
      tick();
      w_lr = 1'b0;
      check("t6w_busy", 64'(w_busy), 64'd1);
      w_si = 64'h0123_4567_89AB_CDEF; w_siv = 1'b1;
      tick();
      w_siv = 1'b0;
      check("t6w_load_done", 64'(w_done), 64'd1);
      check("t6w_mem", w_mem, 64'h0123_4567_89AB_CDEF);
      check("t6w_idle", 64'(w_busy), 64'd0);
      q64.push_back(64'h0123_4567_89AB_CDEF);
      w_dr = 1'b1;
      tick();
      w_dr = 1'b0;
      tick();
      check("t6w_dump_done", 64'(w_done), 64'd1);
      check("t6w_dump_idle", 64'(w_busy), 64'd0);
      check("t6w_mem_after", w_mem, 64'h0123_4567_89AB_CDEF);

      // 6b: LANES=1, 64 beats MSB first
      pat = 64'hC0FF_EE00_1234_5679;
      s_lr = 1'b1;
      tick();
      s_lr = 1'b0;
      for (int i = 0; i < 64; i++) begin
         s_si = pat[63-i]; s_siv = 1'b1;
         tick();
         if (i == 62) check("t6s_done_early", 64'(s_done), 64'd0);
      end
      s_siv = 1'b0;
      check("t6s_load_done", 64'(s_done), 64'd1);
      check("t6s_mem", s_mem, pat);
      for (int i = 0; i < 64; i++) q1.push_back(pat[63-i]);
      s_dr = 1'b1;
      tick();
      s_dr = 1'b0;
      n = 0;
      while (!s_done && n < 100) begin
         tick();
         n++;
      end
      check("t6s_dump_len", 64'(n), 64'd64);
      check("t6s_mem_after", s_mem, pat);

      repeat (3) tick();
      check("q4_empty", 64'(q4.size()), 64'd0);
      check("q64_empty", 64'(q64.size()), 64'd0);
      check("q1_empty", 64'(q1.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
